instruction_fetch_stage: RTL and testbench

- IF stage of the single-issue MIPS pipeline, directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address, which the ROM decodes relative to base 0x0040_0000.
- Captures the ROM's combinational instruction word into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect and out-of-range/misaligned fetch detection.

---
 rtl/mips_pkg.sv | 7 +
 rtl/program_counter.sv | 29 ++
 rtl/instruction_fetch_stage.sv | 61 ++++++
 tb/tb_instruction_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS pipeline stages.
package mips_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with redirect/stall/fault-hold priority and fetch-window fault detection.
module program_counter #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [DATA_WIDTH-1:0] jump_target_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  fault_o
);
  import mips_pkg::*;
  // one extra bit so the window end cannot overflow near the top of the address space
  localparam logic [DATA_WIDTH:0] PC_LIMIT = {1'b0, RESET_PC} + (DATA_WIDTH+1)'(INSTR_BYTES * MEMORY_DEPTH);
  logic [DATA_WIDTH-1:0] pc_d;
  always_comb begin
    fault_o = (|pc_o[1:0]) || (pc_o < RESET_PC) || ({1'b0, pc_o} >= PC_LIMIT);
    pc_d = jump_i ? jump_target_i :
           branch_taken_i ? branch_target_i :
           (fault_o || stall_i) ? pc_o : pc_o + DATA_WIDTH'(INSTR_BYTES);
  end
  always_ff @(posedge clk)
    pc_o <= reset ? RESET_PC : pc_d;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC plus IF/ID pipeline register with flush/stall and a sticky fetch-address fault.
module instruction_fetch_stage #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [DATA_WIDTH-1:0] jump_target_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [DATA_WIDTH-1:0] if_id_instruction_o,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
  output logic                  if_id_valid_o,
  output logic                  addr_fault_o
);
  import mips_pkg::*;
  logic pc_fault;
  logic [DATA_WIDTH-1:0] pc_plus4;
  program_counter #(
    .DATA_WIDTH(DATA_WIDTH),
    .RESET_PC(RESET_PC),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_pc (
    .clk(clk),
    .reset(reset),
    .stall_i(stall_i),
    .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i(jump_i),
    .jump_target_i(jump_target_i),
    .pc_o(pc_o),
    .fault_o(pc_fault)
  );
  assign pc_plus4 = pc_o + DATA_WIDTH'(INSTR_BYTES);
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instruction_o <= DATA_WIDTH'(NOP_INSTR);
      if_id_pc_plus4_o <= '0;
      if_id_valid_o <= 1'b0;
      addr_fault_o <= 1'b0;
    end else begin
      addr_fault_o <= addr_fault_o | pc_fault;
      if (flush_i) begin
        if_id_instruction_o <= DATA_WIDTH'(NOP_INSTR);
        if_id_pc_plus4_o <= '0;
        if_id_valid_o <= 1'b0;
      end else if (!stall_i) begin
        // a faulting fetch still records its PC+4 but never carries the ROM word
        if_id_instruction_o <= pc_fault ? DATA_WIDTH'(NOP_INSTR) : instruction_i;
        if_id_pc_plus4_o <= pc_plus4;
        if_id_valid_o <= !pc_fault;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: scoreboard bench with a ROM model and a fetch-stage reference model.
module tb_instruction_fetch_stage;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int DEPTH = 64;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pp4;
    logic        v;
    logic        af;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, br = 1'b0, jmp = 1'b0;
  logic [31:0] bt = '0, jt = '0;
  logic [31:0] pc, instr, ins_o, pp4_o;
  logic v_o, af_o;
  exp_t q[$];
  exp_t m = '{pc: BASE, ins: 32'h0, pp4: 32'h0, v: 1'b0, af: 1'b0};
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || !(a >= BASE && (a - BASE) < 4 * DEPTH);
  endfunction
  assign instr = rom(pc);
  instruction_fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall),
    .flush_i(flush),
    .branch_taken_i(br),
    .branch_target_i(bt),
    .jump_i(jmp),
    .jump_target_i(jt),
    .pc_o(pc),
    .instruction_i(instr),
    .if_id_instruction_o(ins_o),
    .if_id_pc_plus4_o(pp4_o),
    .if_id_valid_o(v_o),
    .addr_fault_o(af_o)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit s, input bit f, input bit b, input logic [31:0] btv,
                      input bit j, input logic [31:0] jtv);
    exp_t n;
    bit flt;
    @(negedge clk);
    reset = r; stall = s; flush = f; br = b; bt = btv; jmp = j; jt = jtv;
    n = m;
    if (r) n = '{pc: BASE, ins: 32'h0, pp4: 32'h0, v: 1'b0, af: 1'b0};
    else begin
      flt = bad(m.pc);
      n.af = m.af | flt;
      n.pc = j ? jtv : b ? btv : (flt || s) ? m.pc : m.pc + 32'd4;
      if (f) begin
        n.ins = 32'h0; n.pp4 = 32'h0; n.v = 1'b0;
      end else if (!s) begin
        n.ins = flt ? 32'h0 : rom(m.pc);
        n.pp4 = m.pc + 32'd4;
        n.v = !flt;
      end
    end
    q.push_back(n);
    m = n;
  endtask
  task automatic run(input int k);
    repeat (k) step(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask
  task automatic look;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] tgt();
    case ($urandom % 8)
      0: return BASE - 32'd4;
      1: return BASE + 32'd252;
      2: return BASE + 32'd256;
      3: return BASE + ($urandom % 256);
      4: return 32'hFFFF_FFFC;
      default: return BASE + 4 * $urandom_range(0, 63);
    endcase
  endfunction
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("instruction", ins_o, e.ins);
        chk("pc_plus4", pp4_o, e.pp4);
        chk("valid", 32'(v_o), 32'(e.v));
        chk("addr_fault", 32'(af_o), 32'(e.af));
      end
    end
  end
  initial begin : driver
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    run(3);
    look;
    chk("boot_pc", pc, 32'h0040_000C);
    chk("boot_pp4", pp4_o, 32'h0040_000C);
    chk("boot_valid", 32'(v_o), 32'd1);
    run(1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    look;
    chk("stall_pc", pc, 32'h0040_0010);
    chk("stall_pp4", pp4_o, 32'h0040_0010);
    run(1);
    look;
    chk("unstall_pc", pc, 32'h0040_0014);
    chk("unstall_ins", ins_o, rom(32'h0040_0010));
    step(0, 0, 1, 1, 32'h0040_0040, 0, 0);
    look;
    chk("branch_pc", pc, 32'h0040_0040);
    chk("branch_valid", 32'(v_o), 32'd0);
    chk("branch_ins", ins_o, 32'h0);
    run(1);
    look;
    chk("target_ins", ins_o, rom(32'h0040_0040));
    chk("target_valid", 32'(v_o), 32'd1);
    step(0, 0, 1, 0, 0, 1, 32'h0040_00FC);
    run(2);
    look;
    chk("end_fault", 32'(af_o), 32'd1);
    chk("end_valid", 32'(v_o), 32'd0);
    chk("end_pc", pc, 32'h0040_0100);
    step(0, 0, 0, 0, 0, 1, 32'h0040_0000);
    run(1);
    look;
    chk("resume_pc", pc, 32'h0040_0004);
    chk("resume_valid", 32'(v_o), 32'd1);
    chk("resume_fault", 32'(af_o), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0040_0002);
    look;
    chk("misalign_pc", pc, 32'h0040_0002);
    run(1);
    look;
    chk("misalign_fault", 32'(af_o), 32'd1);
    chk("misalign_valid", 32'(v_o), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    look;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_fault", 32'(af_o), 32'd0);
    chk("rst_valid", 32'(v_o), 32'd0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 63) == 0, $urandom % 5 == 0, $urandom % 6 == 0,
           $urandom % 16 == 0, tgt(), $urandom % 16 == 0, tgt());
    repeat (2) @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
